// File: rtl/dma_sync_pkg.sv
// Shared types and defaults for the DMA clock-domain-crossing pulse path.
package dma_sync_pkg;

  localparam int unsigned MIN_GAP_DEF = 6;
  localparam int unsigned PEND_W_DEF  = 8;

  typedef enum logic [0:0] {
    PACER_IDLE = 1'b0,
    PACER_GAP  = 1'b1
  } pacer_state_e;

endpackage

// File: rtl/pulse_pacer_cnt.sv
// Saturating up/down counter of pending events; flags an increment dropped at full scale.
module pulse_pacer_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_a,
  input  logic             reset_a,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt_c,
  output logic             sat_drop
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // inc together with dec cancels out, so a full counter can still accept an event
  always_comb begin
    count_nxt_c = count;
    sat_drop    = 1'b0;
    if (clr) begin
      count_nxt_c = '0;
    end else if (inc && !dec) begin
      if (count == CNT_MAX) begin
        sat_drop = 1'b1;
      end else begin
        count_nxt_c = count + CNT_W'(1);
      end
    end else if (dec && !inc && (count != '0)) begin
      count_nxt_c = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_a) begin
    if (reset_a) begin
      count <= '0;
    end else begin
      count <= count_nxt_c;
    end
  end

endmodule

// File: rtl/pulse_pacer.sv
// Paces single-cycle event strobes into pulses spaced at least MIN_GAP cycles apart,
// keeping a saturating backlog and a sticky overflow flag.
module pulse_pacer
  import dma_sync_pkg::*;
#(
  parameter int unsigned CNT_W   = PEND_W_DEF,
  parameter int unsigned MIN_GAP = MIN_GAP_DEF
) (
  input  logic             clk_a,
  input  logic             reset_a,
  input  logic             evt_in,
  input  logic             flush,
  input  logic             clr_ovf,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned      GAP_W    = $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(1);

  pacer_state_e     state;
  pacer_state_e     state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_nxt;
  logic             want_c;
  logic             issue_c;
  logic [CNT_W-1:0] pend_nxt_c;
  logic             sat_drop_c;

  pulse_pacer_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_a       (clk_a),
    .reset_a     (reset_a),
    .inc         (evt_in & ~flush),
    .dec         (issue_c),
    .clr         (flush),
    .count       (pending),
    .count_nxt_c (pend_nxt_c),
    .sat_drop    (sat_drop_c)
  );

  // flush blocks issuing but lets a running gap finish its countdown
  always_comb begin
    want_c      = ((pending != '0) || evt_in) && !flush;
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    issue_c     = 1'b0;
    case (state)
      PACER_IDLE: begin
        if (want_c) begin
          issue_c     = 1'b1;
          state_nxt   = PACER_GAP;
          gap_cnt_nxt = GAP_LOAD;
        end
      end
      PACER_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (want_c) begin
            issue_c     = 1'b1;
            gap_cnt_nxt = GAP_LOAD;
          end else begin
            state_nxt   = PACER_IDLE;
            gap_cnt_nxt = '0;
          end
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (reset_a) begin
      state     <= PACER_IDLE;
      gap_cnt   <= '0;
      pulse_out <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_cnt_nxt;
      pulse_out <= issue_c;
      overflow  <= sat_drop_c | (overflow & ~clr_ovf);
      busy      <= (state_nxt == PACER_GAP) | (pend_nxt_c != '0);
    end
  end

endmodule

// File: tb/tb_pulse_pacer.sv
// Scoreboard bench for pulse_pacer: an 8-bit and a 2-bit backlog instance share stimulus.
module tb_pulse_pacer;

  localparam int GAP = 6;

  typedef struct packed {
    logic       pulse;
    logic [7:0] pend;
    logic       ovf;
    logic       busy;
  } exp_t;

  logic clk_a = 1'b0;
  logic reset_a, evt_in, flush, clr_ovf;
  logic       p8, ovf8, busy8;
  logic [7:0] pend8;
  logic       p2, ovf2, busy2;
  logic [1:0] pend2;

  always #5 clk_a = ~clk_a;

  pulse_pacer #(.CNT_W(8), .MIN_GAP(GAP)) u_dut8 (
    .clk_a(clk_a), .reset_a(reset_a), .evt_in(evt_in), .flush(flush), .clr_ovf(clr_ovf),
    .pulse_out(p8), .pending(pend8), .overflow(ovf8), .busy(busy8)
  );

  pulse_pacer #(.CNT_W(2), .MIN_GAP(GAP)) u_dut2 (
    .clk_a(clk_a), .reset_a(reset_a), .evt_in(evt_in), .flush(flush), .clr_ovf(clr_ovf),
    .pulse_out(p2), .pending(pend2), .overflow(ovf2), .busy(busy2)
  );

  exp_t q8[$];
  exp_t q2[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   m_pend[2];
  int   m_since[2];
  logic m_ovf[2];
  int   m_max[2] = '{255, 3};
  int   pulses8[$];
  int   pulses2[$];
  int   last8 = -1000;
  int   ovf2_first = -1;
  int   t0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Reference: a pulse may issue once MIN_GAP-1 cycles have passed since the last pulse cycle.
  task automatic model_step(input int i, input logic e, input logic f, input logic c,
                            input logic r, output exp_t x);
    logic iss, drop;
    iss  = 1'b0;
    drop = 1'b0;
    if (r) begin
      m_pend[i]  = 0;
      m_since[i] = 1000;
      m_ovf[i]   = 1'b0;
    end else begin
      iss = ((m_pend[i] != 0) || e) && !f && (m_since[i] >= GAP - 1);
      if (f) m_pend[i] = 0;
      else if (e && !iss) begin
        if (m_pend[i] == m_max[i]) drop = 1'b1;
        else m_pend[i]++;
      end else if (iss && !e) m_pend[i]--;
      m_ovf[i]   = drop | (m_ovf[i] & !c);
      m_since[i] = iss ? 0 : ((m_since[i] >= 1000) ? 1000 : m_since[i] + 1);
    end
    x.pulse = iss;
    x.pend  = 8'(m_pend[i]);
    x.ovf   = m_ovf[i];
    x.busy  = (m_since[i] < GAP) || (m_pend[i] != 0);
  endtask

  task automatic step(input logic e, input logic f, input logic c, input logic r);
    exp_t x8, x2, o8, o2;
    reset_a = r;
    evt_in  = e;
    flush   = f;
    clr_ovf = c;
    model_step(0, e, f, c, r, x8);
    q8.push_back(x8);
    model_step(1, e, f, c, r, x2);
    q2.push_back(x2);
    @(posedge clk_a);
    #1;
    cyc++;
    o8 = q8.pop_front();
    o2 = q2.pop_front();
    check_eq("pulse8", 32'(p8), 32'(o8.pulse));
    check_eq("pend8", 32'(pend8), 32'(o8.pend));
    check_eq("ovf8", 32'(ovf8), 32'(o8.ovf));
    check_eq("busy8", 32'(busy8), 32'(o8.busy));
    check_eq("pulse2", 32'(p2), 32'(o2.pulse));
    check_eq("pend2", 32'(pend2), 32'(o2.pend));
    check_eq("ovf2", 32'(ovf2), 32'(o2.ovf));
    check_eq("busy2", 32'(busy2), 32'(o2.busy));
    if (r) last8 = -1000;
    if (p8) begin
      check_eq("spacing8", 32'(cyc - last8 >= GAP), 32'd1);
      last8 = cyc;
      pulses8.push_back(cyc);
    end
    if (p2) pulses2.push_back(cyc);
    if (ovf2 && ovf2_first < 0) ovf2_first = cyc;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_train(input string tag, input int got[$], input int start, input int n);
    check_eq({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (got.size() > k) check_eq(tag, 32'(got[k]), 32'(start + 1 + GAP * k));
    end
  endtask

  initial begin
    reset_a = 1'b1;
    evt_in  = 1'b0;
    flush   = 1'b0;
    clr_ovf = 1'b0;
    m_pend  = '{0, 0};
    m_since = '{1000, 1000};
    m_ovf   = '{1'b0, 1'b0};

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_pend", 32'(pend8), 32'd0);
    check_eq("rst_busy", 32'(busy8), 32'd0);
    idle(2);

    // single event
    t0 = cyc; pulses8.delete();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("single_lat", 32'(p8), 32'd1);
    idle(9);
    check_train("single", pulses8, t0, 1);

    // burst of five
    t0 = cyc; pulses8.delete();
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("burst_peak", 32'(pend8), 32'd4);
    idle(30);
    check_train("burst", pulses8, t0, 5);
    check_eq("burst_ovf", 32'(ovf8), 32'd0);

    // overflow on the 2-bit instance
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    t0 = cyc; pulses2.delete(); ovf2_first = -1;
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(24);
    check_eq("ovf_first", 32'(ovf2_first), 32'(t0 + 5));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("ovf_clr", 32'(ovf2), 32'd0);
    check_train("ovf_pulses", pulses2, t0, 4);
    idle(12);

    // event on the issue edge with backlog of two
    t0 = cyc; pulses8.delete();
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("simul_pend", 32'(pend8), 32'd2);
    idle(20);
    check_train("simul", pulses8, t0, 4);

    // flush mid-gap
    t0 = cyc; pulses8.delete();
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("flush_pend", 32'(pend8), 32'd0);
    idle(15);
    check_train("flush", pulses8, t0, 1);
    check_eq("flush_busy", 32'(busy8), 32'd0);

    // reset mid-gap with backlog of five
    pulses8.delete();
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("prerst_pend", 32'(pend8), 32'd5);
    pulses8.delete();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("midrst_pend", 32'(pend8), 32'd0);
    check_eq("midrst_busy", 32'(busy8), 32'd0);
    idle(10);
    check_eq("midrst_quiet", 32'(pulses8.size()), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("postrst_pulse", 32'(p8), 32'd1);
    idle(10);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 3),
           1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 99) < 1));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_pacer.md
# pulse_pacer

Source-domain event pacer for the DMA clock-domain-crossing path. It accepts single-cycle event strobes at any rate and counts pending events. It emits one-cycle pulses spaced at least MIN_GAP cycles apart, so the downstream toggle/4-flop pulse synchronizer never sees two events closer than it can resolve. Events are never merged or lost silently: excess backlog is counted, and counter saturation raises a sticky overflow flag.

## Interface
Parameters:
- CNT_W, 8, width of the pending-event counter; maximum backlog is 2^CNT_W-1.
- MIN_GAP, 6, minimum clk_a cycles between rising edges of pulse_out; legal range is ≥2.

Ports:
- clk_a  input  1  source-domain clock; the single clock of the block.
- reset_a  input  1  synchronous, active-high reset.
- evt_in  input  1  event strobe; each high cycle is one event; may be high on consecutive cycles.
- flush  input  1  discards all pending events; does not shorten an active gap.
- clr_ovf  input  1  clears the sticky overflow flag.
- pulse_out  output  1  registered one-cycle pulse; drives the synchronizer's signal_in.
- pending  output  CNT_W  registered count of events not yet emitted.
- overflow  output  1  sticky; set when an event is dropped because the counter is saturated.
- busy  output  1  high when state is GAP or pending≠0.

## Operation
- FSM states:
  - IDLE: no gap running.
  - GAP: gap countdown active; gap_cnt holds cycles remaining.
- Issue condition: `want = (pending≠0) | evt_in`, qualified by `!flush`.
- IDLE with want:
  - pulse_out=1 next cycle.
  - State→GAP, gap_cnt←MIN_GAP.
- GAP:
  - gap_cnt decrements each cycle.
  - When gap_cnt==1 and want: pulse next cycle, gap_cnt←MIN_GAP, stay in GAP.
  - When gap_cnt==1 and !want: →IDLE.
- pending update, per cycle: `next = pending + (evt_in accepted) − (pulse issued this edge)`.
  - An issued pulse consumes an existing pending event first; if pending==0, it consumes the same-cycle evt_in.
  - evt_in together with an issue leaves pending unchanged.
- Saturation:
  - evt_in with pending==2^CNT_W-1 and no issue that edge: event dropped, overflow←1.
  - If an issue happens that same edge, the event is accepted and no overflow occurs.
- flush:
  - pending←0.
  - evt_in in the same cycle is also discarded; it does not set overflow.
  - No pulse is issued on that edge.
  - The gap timer continues.
- clr_ovf:
  - Clears overflow.
  - If a drop occurs in the same cycle, set wins.
- Width rules: pending arithmetic is unsigned CNT_W bits with no wrap-around. gap_cnt is $clog2(MIN_GAP+1) bits.

## Timing
- Reset values: pulse_out=0, pending=0, overflow=0, busy=0, state IDLE, gap_cnt=0.
- Reset applied mid-gap or with backlog: everything is cleared on the next edge. No pulse is issued in the cycle after reset is deasserted unless evt_in is high in that cycle.
- Latency from evt_in in IDLE with pending=0 to pulse_out is 1 cycle.
- Spacing while backlogged: pulse_out high 1 cycle, then low MIN_GAP-1 cycles, repeating; consecutive rising edges are exactly MIN_GAP apart.
- pending reflects the accepted event one cycle after evt_in.
- overflow is visible one cycle after the dropped event.
- pulse_out is never high two consecutive cycles. The spacing between pulses is never less than MIN_GAP, under any input pattern.

## Structure
- Shared package dma_sync_pkg holds:
  - the FSM state enum (PACER_IDLE, PACER_GAP);
  - the default constants MIN_GAP_DEF=6 and PEND_W_DEF=8.
- One sub-module: pulse_pacer_cnt. It is the saturating up/down pending counter, with inputs inc, dec, clr and outputs count, sat_drop.
- FSM and gap counter live in pulse_pacer itself.

## Test plan
1. Single event (MIN_GAP=6): evt_in high at cycle t, idle block → pulse_out high only at t+1; pending stays 0; busy high t+1..t+6, low at t+7.
2. Burst of 5 back-to-back events at t..t+4 → pulses at t+1, t+7, t+13, t+19, t+25; pending peaks at 4; overflow stays 0.
3. Overflow (CNT_W=2, MIN_GAP=6): evt_in high t..t+5 → pending reaches 3 at t+4; events at t+4 and t+5 dropped; overflow=1 from t+5. Pulses at t+1, t+7, t+13, t+19 only. clr_ovf at t+30 → overflow=0 at t+31.
4. Simultaneous events (pending=2, MIN_GAP=6): evt_in coincides with the issue edge → pending stays 2, and the next pulse is still exactly MIN_GAP after the previous one.
5. Flush: pending=3 mid-gap, flush high for 1 cycle → pending=0 next cycle; no further pulses; state returns to IDLE when the gap expires.
6. Reset mid-gap: reset_a high for 1 cycle with pending=5 → all outputs 0 next cycle; no pulse afterwards. A new evt_in after reset → pulse 1 cycle later.
